block_row_buffer: RTL and testbench



---
 rtl/block_row_buffer.sv | 132 +++++++++++++
 tb/tb_block_row_buffer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/block_row_buffer.sv
// Ping-pong buffer: captures whole 8x8 coefficient blocks and replays them one row per beat.
// Latency: a block captured at edge N presents row 0 in cycle N+1; back-to-back blocks stream with no bubble.
// Backpressure: rows hold while row_ready is low; a block arriving with both banks full is dropped and flags overflow.
module block_row_buffer #(
    parameter int COEF_WIDTH = 8,
    parameter int BLOCK_DIM  = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [BLOCK_DIM*BLOCK_DIM*COEF_WIDTH-1:0] table_value,
    input  logic                                    table_valid,
    output logic [BLOCK_DIM*COEF_WIDTH-1:0]         row_data,
    output logic [$clog2(BLOCK_DIM)-1:0]            row_index,
    output logic                                    row_last,
    output logic                                    row_valid,
    input  logic                                    row_ready,
    output logic                                    overflow,
    output logic                                    busy
);

    localparam int ROW_W = BLOCK_DIM * COEF_WIDTH;
    localparam int BLK_W = BLOCK_DIM * ROW_W;
    localparam int IW    = $clog2(BLOCK_DIM);
    localparam logic [IW-1:0] LAST_ROW = IW'(BLOCK_DIM - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      count_q, count_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [IW-1:0]   row_q, row_d;
    logic            overflow_q, overflow_d;

    // Bank storage carries no reset: contents are only read once count says they are full.
    logic [BLK_W-1:0] bank_q [2];

    logic transfer;
    logic last_xfer;
    logic space;
    logic capture;

    assign row_valid = (state_q == S_STREAM);
    assign transfer  = row_valid && row_ready;
    assign last_xfer = transfer && (row_q == LAST_ROW);
    // A full buffer still has room if the draining block leaves in this same cycle.
    assign space     = (count_q != 2'd2) || last_xfer;
    assign capture   = table_valid && space;

    assign row_data  = bank_q[rd_bank_q][row_q*ROW_W +: ROW_W];
    assign row_index = row_q;
    assign row_last  = row_valid && (row_q == LAST_ROW);
    assign busy      = (count_q != 2'd0);
    assign overflow  = overflow_q;

    // Write the whole incoming block into the free bank on capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            bank_q[wr_bank_q] <= table_value;
        end
    end

    // Control and FSM state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            count_q    <= 2'd0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            row_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            row_q      <= row_d;
            overflow_q <= overflow_d;
        end
    end

    // Next-state: pointer/occupancy bookkeeping and the IDLE/STREAM read FSM.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        row_d      = row_q;
        overflow_d = overflow_q;

        if (capture) begin
            wr_bank_d = ~wr_bank_q;
        end
        if (table_valid && !space) begin
            overflow_d = 1'b1;
        end

        if (transfer) begin
            if (row_q == LAST_ROW) begin
                row_d     = '0;
                rd_bank_d = ~rd_bank_q;
            end else begin
                row_d = row_q + 1'b1;
            end
        end

        // Simultaneous capture and block completion leave occupancy unchanged.
        case ({capture, last_xfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (last_xfer && (count_d == 2'd0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_block_row_buffer.sv
// Testbench for block_row_buffer: directed scenarios plus random traffic against a block-queue model.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Row ready pattern and block arrival are randomised in the final phase.
module tb_block_row_buffer;

    localparam int CW    = 8;
    localparam int DIM   = 8;
    localparam int ROW_W = DIM * CW;
    localparam int BLK_W = DIM * ROW_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [BLK_W-1:0] table_value = '0;
    logic             table_valid = 1'b0;
    logic [ROW_W-1:0] row_data;
    logic [2:0]       row_index;
    logic             row_last;
    logic             row_valid;
    logic             row_ready = 1'b0;
    logic             overflow;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO of accepted blocks, row pointer into the head, sticky overflow.
    logic [BLK_W-1:0] blk_q[$];
    int               rd_row = 0;
    bit               m_ovf  = 1'b0;

    block_row_buffer #(.COEF_WIDTH(CW), .BLOCK_DIM(DIM)) dut (
        .clk         (clk),
        .rst         (rst),
        .table_value (table_value),
        .table_valid (table_valid),
        .row_data    (row_data),
        .row_index   (row_index),
        .row_last    (row_last),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .overflow    (overflow),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BLK_W-1:0] fill_blk(input logic [7:0] b);
        logic [BLK_W-1:0] v;
        for (int i = 0; i < DIM*DIM; i++) v[i*CW +: CW] = b;
        return v;
    endfunction

    function automatic logic [BLK_W-1:0] ramp_blk(input logic [7:0] base);
        logic [BLK_W-1:0] v;
        for (int i = 0; i < DIM*DIM; i++) v[i*CW +: CW] = base + 8'(i);
        return v;
    endfunction

    function automatic logic [BLK_W-1:0] rand_blk();
        logic [BLK_W-1:0] v;
        for (int i = 0; i < BLK_W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Compare DUT outputs against the model state for the current cycle.
    task automatic compare_outputs();
        bit exp_vld;
        exp_vld = (blk_q.size() > 0);
        check_eq("row_valid", 64'(row_valid), 64'(exp_vld));
        check_eq("busy", 64'(busy), 64'(exp_vld));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        if (exp_vld) begin
            logic [BLK_W-1:0] head;
            head = blk_q[0];
            check_eq("row_data", 64'(row_data), 64'(head[rd_row*ROW_W +: ROW_W]));
            check_eq("row_index", 64'(row_index), 64'(rd_row));
            check_eq("row_last", 64'(row_last), 64'(rd_row == DIM-1));
        end
    endtask

    // One cycle: check at the falling edge, drive inputs, advance the model over the next rising edge.
    task automatic step(input bit tv, input logic [BLK_W-1:0] val, input bit rdy);
        bit xfer, last, room;
        @(negedge clk);
        compare_outputs();
        table_valid = tv;
        table_value = val;
        row_ready   = rdy;
        xfer = (blk_q.size() > 0) && rdy;
        last = xfer && (rd_row == DIM-1);
        room = (blk_q.size() < 2) || last;
        if (last) begin
            void'(blk_q.pop_front());
            rd_row = 0;
        end else if (xfer) begin
            rd_row++;
        end
        if (tv) begin
            if (room) blk_q.push_back(val);
            else      m_ovf = 1'b1;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
    endtask

    // Short asynchronous reset pulse between clock edges.
    task automatic pulse_reset();
        @(negedge clk);
        table_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_eq("rst_row_valid", 64'(row_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_overflow", 64'(overflow), 64'd0);
        check_eq("rst_row_index", 64'(row_index), 64'd0);
        rst = 1'b0;
        blk_q.delete();
        rd_row = 0;
        m_ovf  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Power-on reset state.
        #12;
        check_eq("init_row_valid", 64'(row_valid), 64'd0);
        check_eq("init_row_index", 64'(row_index), 64'd0);
        check_eq("init_row_last", 64'(row_last), 64'd0);
        check_eq("init_overflow", 64'(overflow), 64'd0);
        check_eq("init_busy", 64'(busy), 64'd0);
        rst = 1'b0;

        // Single block, byte i = i, ready held high.
        step(1'b1, ramp_blk(8'd0), 1'b1);
        idle(12, 1'b1);

        // Back-pressure with ready pattern 1,0,0 repeating.
        step(1'b1, ramp_blk(8'd0), 1'b1);
        for (int k = 0; k < 30; k++) step(1'b0, '0, (k % 3) == 2);

        // Ping-pong: second block three cycles after the first.
        step(1'b1, fill_blk(8'h11), 1'b1);
        idle(2, 1'b1);
        step(1'b1, fill_blk(8'h22), 1'b1);
        idle(18, 1'b1);

        // Overflow: three blocks with ready low; third must be dropped.
        step(1'b1, fill_blk(8'hA1), 1'b0);
        step(1'b1, fill_blk(8'hB2), 1'b0);
        step(1'b1, fill_blk(8'hC3), 1'b0);
        idle(3, 1'b0);
        idle(20, 1'b1);
        pulse_reset();

        // Coincident capture with the last-row transfer of a full buffer.
        step(1'b1, ramp_blk(8'h40), 1'b0);
        step(1'b1, ramp_blk(8'h80), 1'b0);
        idle(7, 1'b1);
        step(1'b1, ramp_blk(8'hC0), 1'b1);
        idle(26, 1'b1);

        // Reset mid-stream at row 3, then a fresh block starts at row 0.
        step(1'b1, ramp_blk(8'h10), 1'b1);
        for (int k = 0; k < 20 && rd_row != 3; k++) step(1'b0, '0, 1'b1);
        pulse_reset();
        idle(10, 1'b1);
        step(1'b1, ramp_blk(8'h20), 1'b1);
        idle(10, 1'b1);

        // Sustained one block per 8 cycles: never overflows.
        for (int k = 0; k < 160; k++) step((k % 8) == 0, rand_blk(), 1'b1);
        idle(10, 1'b1);

        // Random traffic and back-pressure.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 5) == 0, rand_blk(), $urandom_range(0, 9) < 7);
            if (k == 1500) pulse_reset();
        end
        idle(40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
